// File: rtl/cipher_byte_uart_framer.sv
// Ciphertext byte FIFO feeding a UART framer (start, 8 data LSB first, even parity, stop) with a per-packet XOR checksum frame.
// Latency: byte strobed at edge E pops at E+1, tx falls at E+2; no backpressure, bytes arriving on a full FIFO are dropped and flagged in overflow.
module cipher_byte_uart_framer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int PKT_LEN      = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [7:0]                       in_data,
   input  logic                             in_valid,
   input  logic                             flush,
   output logic                             tx,
   output logic                             busy,
   output logic                             overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state, state_nxt;
   logic [7:0]          mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [LVL_W-1:0]    level;
   logic [7:0]          shift_q, cksum, cksum_hold, head, cksum_next;
   logic                parity_q, pending;
   logic [7:0]          pkt_cnt;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [2:0]          bit_cnt;
   logic                fifo_full, fifo_empty, push, pop, load_ck, baud_last;

   assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign push       = in_valid && !flush && !fifo_full;
   assign head       = mem[rd_ptr];
   assign cksum_next = cksum ^ head;
   assign baud_last  = (baud_cnt == BAUD_W'(CLKS_PER_BIT-1));
   assign busy       = (state != IDLE) || !fifo_empty || pending;
   assign fifo_level = level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // The pending checksum always wins over the FIFO so it directly follows its packet.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load_ck   = 1'b0;
      case (state)
         IDLE: begin
            if (!flush) begin
               if (pending) begin
                  load_ck   = 1'b1;
                  state_nxt = START;
               end else if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end
            end
         end
         START:   if (baud_last) state_nxt = DATA;
         DATA:    if (baud_last && bit_cnt == 3'd7) state_nxt = PARITY;
         PARITY:  if (baud_last) state_nxt = STOP;
         STOP:    if (baud_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level <= level + LVL_W'(1);
         else if (!push && pop) level <= level - LVL_W'(1);
         // A full FIFO drops the byte even if a pop frees a slot this cycle.
         if (in_valid && fifo_full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cksum      <= 8'h00;
         cksum_hold <= 8'h00;
         pkt_cnt    <= 8'd0;
         pending    <= 1'b0;
      end else if (flush) begin
         cksum   <= 8'h00;
         pkt_cnt <= 8'd0;
         pending <= 1'b0;
      end else if (load_ck) begin
         pending <= 1'b0;
      end else if (pop) begin
         if (pkt_cnt == 8'(PKT_LEN-1)) begin
            cksum_hold <= cksum_next;
            pending    <= 1'b1;
            cksum      <= 8'h00;
            pkt_cnt    <= 8'd0;
         end else begin
            cksum   <= cksum_next;
            pkt_cnt <= pkt_cnt + 8'd1;
         end
      end
   end

   // tx is registered from the current state, so it trails the FSM by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q  <= 8'h00;
         parity_q <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
         tx       <= 1'b1;
      end else begin
         if (state == IDLE || baud_last) baud_cnt <= '0;
         else                            baud_cnt <= baud_cnt + BAUD_W'(1);

         if (load_ck) begin
            shift_q  <= cksum_hold;
            parity_q <= ^cksum_hold;
            bit_cnt  <= 3'd0;
         end else if (pop) begin
            shift_q  <= head;
            parity_q <= ^head;
            bit_cnt  <= 3'd0;
         end else if (state == DATA && baud_last) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end

         case (state)
            START:   tx <= 1'b0;
            DATA:    tx <= shift_q[0];
            PARITY:  tx <= parity_q;
            default: tx <= 1'b1;
         endcase
      end
   end
endmodule
